seq_checker_param: RTL and testbench
====================================

# seq_checker_param

Parametrised sequence checker for the robot game: an expected digit sequence is loaded through a write port, then player digits are compared one per valid cycle, with mismatches counted against a configurable error budget. It generalises the fixed 4-bit / 6-step checker to any digit width, sequence length and error limit. It also adds a loadable sequence, a run/stop handshake and progress/error counters. It sits between the keypad/test-vector source and the LED/display driver.

## Interface
- DIGIT_W, 4, width of one sequence digit
- SEQ_LEN, 6, number of digits in the sequence (≥2)
- MAX_ERRORS, 3, mismatches that end the game (≥1)
- Derived widths: IDX_W = $clog2(SEQ_LEN+1), ERR_W = $clog2(MAX_ERRORS+1)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_valid  in  1  write load_data into the next sequence slot
- load_data  in  DIGIT_W  expected digit
- load_ready  out  1  high in IDLE while fewer than SEQ_LEN digits are loaded
- start  in  1  pulse: begin the game (accepted only in IDLE when the sequence is full)
- clear  in  1  pulse: abort/reset the game; in IDLE it also flushes the loaded sequence
- number_valid  in  1  player digit present
- number  in  DIGIT_W  player digit
- error_led  out  1  one-cycle pulse per mismatch
- state_display  out  2  00 IDLE, 01 RUN, 10 DONE, 11 FAIL
- progress  out  IDX_W  digits matched so far
- err_count  out  ERR_W  mismatches so far
- seq_loaded  out  1  all SEQ_LEN slots written

## Operation
- Storage: SEQ_LEN × DIGIT_W register array, write pointer wr_ptr (0..SEQ_LEN).
- IDLE: when load_valid && load_ready, mem[wr_ptr] ← load_data and wr_ptr++. seq_loaded = (wr_ptr == SEQ_LEN). load_valid is ignored when load_ready=0. start with seq_loaded=1 → RUN, with progress=0 and err_count=0. start with seq_loaded=0 is ignored.
- RUN: number_valid compares number with mem[progress].
  - Match: progress++. If the new progress equals SEQ_LEN → DONE.
  - Mismatch: error_led pulses and err_count++. If the new err_count equals MAX_ERRORS → FAIL. Otherwise progress is handled per Configuration.
- DONE, FAIL: number_valid, load_valid and start are ignored. Outputs hold until clear.
- clear, in any state other than IDLE: → IDLE, progress=0, err_count=0. The sequence is retained, so start can replay it.
- clear in IDLE: wr_ptr=0 and seq_loaded=0. Memory contents need not be zeroed.
- Priority within a cycle: clear > start > number_valid > load_valid. A digit arriving on the same edge as start is ignored, because the checker is still in IDLE that cycle.
- The match on the last digit and the MAX_ERRORS-th mismatch are mutually exclusive, since only one digit is consumed per cycle.
- Counters saturate by construction: progress ≤ SEQ_LEN and err_count ≤ MAX_ERRORS.

## Timing
- All outputs are registered and update on the rising edge that samples the input. Latency from input to output is 1 cycle.
- error_led is high for exactly the one cycle after a mismatching number_valid. Back-to-back mismatches give back-to-back pulses.
- number_valid may be held high for consecutive cycles; one digit is consumed per cycle.
- Reset values (reset_n low, asynchronous): state IDLE (state_display=00), error_led=0, progress=0, err_count=0, wr_ptr=0, seq_loaded=0, load_ready=1.
- Reset asserted mid-game or mid-load returns the block to the reset values immediately. The loaded sequence is lost.

## Configuration
- SEQ_CHECKER_RESTART_EN defined: a mismatch in RUN also sets progress=0, so the player restarts from the first digit.
- SEQ_CHECKER_RESTART_EN undefined: a mismatch leaves progress unchanged, so the player retries the same step.
- All other behaviour is identical in both builds.

## Test plan
- Defaults: load 3,1,4,1,5,9, then start, then feed 3,1,4,1,5,9. Required: progress goes 1..6, state_display goes 01→10 on the 6th digit, error_led never fires, err_count=0.
- Same sequence, feed 3,7,1,4,1,5,9 (macro off). Required: a single error_led pulse after the 7, progress stays at 1 after the pulse, final state_display=10, err_count=1.
- Same sequence, feed 3,1,8 with the macro on. Required: error_led pulse, progress 2→0, state_display stays 01.
- Feed 0,0,0. Required: three error_led pulses, err_count=3, state_display=11. A following correct 3 leaves all outputs unchanged.
- Load only 5 digits, then start. Required: state stays 00 and load_ready=1. Load a 6th digit: seq_loaded=1 and load_ready=0, and a 7th load_valid is ignored.
- Two reset/clear cases, each from RUN with progress=3:
  - Assert reset_n=0. Required: all outputs are at reset values within the same cycle, and seq_loaded=0 afterwards.
  - Separately pulse clear. Required: state 00, progress 0, seq_loaded stays 1, and start replays the sequence.

Source files
------------

// File: rtl/seq_checker_param.sv
// -----------------------------------------------------------------------------
// seq_checker_param
//
// Parametrised sequence checker for the robot game. An expected digit
// sequence is written through a load port while IDLE; after start, player
// digits are compared one per number_valid cycle against the stored sequence.
// Matches advance progress; mismatches pulse error_led and count against an
// error budget. The game ends in DONE (full sequence matched) or FAIL
// (MAX_ERRORS mismatches) and holds there until clear.
//
// Parameters:
//   DIGIT_W    width of one digit
//   SEQ_LEN    digits in the sequence (>= 2)
//   MAX_ERRORS mismatches that end the game (>= 1)
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   load_valid/data     write next sequence slot (IDLE, while load_ready)
//   load_ready          IDLE and fewer than SEQ_LEN digits loaded
//   start               begin game (IDLE with full sequence only)
//   clear               abort game; in IDLE also flushes the sequence
//   number_valid/number player digit
//   error_led           one-cycle pulse per mismatch
//   state_display       00 IDLE, 01 RUN, 10 DONE, 11 FAIL
//   progress            digits matched so far
//   err_count           mismatches so far
//   seq_loaded          all SEQ_LEN slots written
//
// Build option:
//   SEQ_CHECKER_RESTART_EN  when defined, a mismatch also resets progress to 0
//                           (restart from first digit); otherwise the player
//                           retries the same step.
// -----------------------------------------------------------------------------
module seq_checker_param #(
  parameter int DIGIT_W    = 4,
  parameter int SEQ_LEN    = 6,
  parameter int MAX_ERRORS = 3,
  localparam int IDX_W     = $clog2(SEQ_LEN + 1),
  localparam int ERR_W     = $clog2(MAX_ERRORS + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load_valid,
  input  logic [DIGIT_W-1:0] load_data,
  output logic               load_ready,
  input  logic               start,
  input  logic               clear,
  input  logic               number_valid,
  input  logic [DIGIT_W-1:0] number,
  output logic               error_led,
  output logic [1:0]         state_display,
  output logic [IDX_W-1:0]   progress,
  output logic [ERR_W-1:0]   err_count,
  output logic               seq_loaded
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_FAIL = 2'b11;

  localparam logic [IDX_W-1:0] SEQ_LEN_C = IDX_W'(SEQ_LEN);
  localparam logic [ERR_W-1:0] MAX_ERR_C = ERR_W'(MAX_ERRORS);

  logic [1:0]         state_q,     state_d;
  logic [IDX_W-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [IDX_W-1:0]   progress_q,  progress_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               error_led_q, error_led_d;

  logic [DIGIT_W-1:0] mem_q [SEQ_LEN];
  logic               mem_we;

  logic               full;
  logic [IDX_W-1:0]   progress_inc;
  logic [ERR_W-1:0]   err_inc;

  assign full         = (wr_ptr_q == SEQ_LEN_C);
  assign progress_inc = progress_q + IDX_W'(1);
  assign err_inc      = err_count_q + ERR_W'(1);

  // Next-state logic. Priority: clear > start > number_valid > load_valid.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    progress_d  = progress_q;
    err_count_d = err_count_q;
    error_led_d = 1'b0;
    mem_we      = 1'b0;

    if (clear) begin
      state_d     = ST_IDLE;
      progress_d  = '0;
      err_count_d = '0;
      // Sequence survives a game abort so start can replay it; only a clear
      // issued while already idle flushes it.
      if (state_q == ST_IDLE) wr_ptr_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && full) begin
            state_d     = ST_RUN;
            progress_d  = '0;
            err_count_d = '0;
          end else if (load_valid && !full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
          end
        end
        ST_RUN: begin
          if (number_valid) begin
            // progress_q < SEQ_LEN while in RUN, so the index is in range.
            if (number == mem_q[progress_q]) begin
              progress_d = progress_inc;
              if (progress_inc == SEQ_LEN_C) state_d = ST_DONE;
            end else begin
              error_led_d = 1'b1;
              err_count_d = err_inc;
              if (err_inc == MAX_ERR_C) begin
                state_d = ST_FAIL;
              end else begin
`ifdef SEQ_CHECKER_RESTART_EN
                progress_d = '0;
`else
                progress_d = progress_q;
`endif
              end
            end
          end
        end
        default: ; // DONE / FAIL hold until clear
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample the same pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      progress_q  <= '0;
      err_count_q <= '0;
      error_led_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      progress_q  <= progress_d;
      err_count_q <= err_count_d;
      error_led_q <= error_led_d;
    end
  end

  // NOTE: the digit storage has no reset; its contents are meaningless until
  // rewritten because wr_ptr_q returns to 0, so a reset would only cost area.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[wr_ptr_q] <= load_data;
  end

  assign load_ready    = (state_q == ST_IDLE) && !full;
  assign seq_loaded    = full;
  assign state_display = state_q;
  assign progress      = progress_q;
  assign err_count     = err_count_q;
  assign error_led     = error_led_q;

endmodule

// File: tb/tb_seq_checker_param.sv
// -----------------------------------------------------------------------------
// tb_seq_checker_param
//
// Directed testbench for seq_checker_param with default parameters
// (DIGIT_W=4, SEQ_LEN=6, MAX_ERRORS=3) and sequence 3,1,4,1,5,9. Expected
// values are hand-computed; the restart-on-mismatch build option changes a
// few of them, selected with SEQ_CHECKER_RESTART_EN.
// -----------------------------------------------------------------------------
module tb_seq_checker_param;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load_valid;
  logic [3:0] load_data;
  logic       load_ready;
  logic       start;
  logic       clear;
  logic       number_valid;
  logic [3:0] number;
  logic       error_led;
  logic [1:0] state_display;
  logic [2:0] progress;
  logic [1:0] err_count;
  logic       seq_loaded;

  int n_cmp = 0;
  int n_bad = 0;

  seq_checker_param dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .start        (start),
    .clear        (clear),
    .number_valid (number_valid),
    .number       (number),
    .error_led    (error_led),
    .state_display(state_display),
    .progress     (progress),
    .err_count    (err_count),
    .seq_loaded   (seq_loaded)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One clock edge; returns 1 time unit after it so outputs are settled and
  // new inputs are set up well before the next edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    load_valid   = 1'b0;
    load_data    = '0;
    start        = 1'b0;
    clear        = 1'b0;
    number_valid = 1'b0;
    number       = '0;
  endtask

  task automatic load(input logic [3:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Present one player digit; caller drops number_valid when the burst ends,
  // so consecutive feed() calls hold number_valid high back to back.
  task automatic feed(input logic [3:0] d);
    number_valid = 1'b1;
    number       = d;
    tick();
  endtask

  task automatic end_feed;
    number_valid = 1'b0;
    tick();
  endtask

  logic [3:0] seq [6] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9};

`ifdef SEQ_CHECKER_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #12;
    // ---------------- reset values
    check("rst_state",     state_display, 0);
    check("rst_progress",  progress,      0);
    check("rst_err",       err_count,     0);
    check("rst_led",       error_led,     0);
    check("rst_loaded",    seq_loaded,    0);
    check("rst_ready",     load_ready,    1);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // ---------------- partial load, start ignored, 6th fills, 7th ignored
    for (int i = 0; i < 5; i++) load(seq[i]);
    check("part_loaded", seq_loaded, 0);
    check("part_ready",  load_ready, 1);
    pulse_start();
    check("part_start_state", state_display, 0);
    check("part_start_ready", load_ready,    1);
    load(seq[5]);
    check("full_loaded", seq_loaded, 1);
    check("full_ready",  load_ready, 0);
    load(4'd7);
    check("extra_loaded", seq_loaded, 1);
    check("extra_ready",  load_ready, 0);

    // ---------------- start with a digit on the same edge: digit ignored
    start = 1'b1; number_valid = 1'b1; number = 4'd3;
    tick();
    start = 1'b0; number_valid = 1'b0;
    check("start_state",    state_display, 1);
    check("start_progress", progress,      0);
    check("start_ready",    load_ready,    0);

    // ---------------- full correct run
    for (int i = 0; i < 6; i++) begin
      feed(seq[i]);
      check($sformatf("ok_progress%0d", i), progress, i + 1);
      check($sformatf("ok_led%0d", i),      error_led, 0);
      check($sformatf("ok_state%0d", i),    state_display, (i == 5) ? 2 : 1);
    end
    end_feed();
    check("ok_err", err_count, 0);
    // DONE ignores digits and start
    feed(4'd3);
    number_valid = 1'b0;
    pulse_start();
    check("done_hold_progress", progress,      6);
    check("done_hold_state",    state_display, 2);

    // ---------------- one wrong digit mid-game, then completion
    pulse_clear();
    check("clr_state",    state_display, 0);
    check("clr_progress", progress,      0);
    check("clr_loaded",   seq_loaded,    1);
    pulse_start();
    feed(4'd3);
    feed(4'd7);
    check("wrong_led",      error_led, 1);
    check("wrong_err",      err_count, 1);
    check("wrong_progress", progress,  RESTART ? 0 : 1);
    if (RESTART) begin
      feed(4'd3);
      check("retry_led", error_led, 0);
    end
    for (int i = 1; i < 6; i++) begin
      feed(seq[i]);
      if (i == 1) check("after_wrong_led", error_led, 0);
    end
    end_feed();
    check("wrong_final_state", state_display, 2);
    check("wrong_final_err",   err_count,     1);
    check("wrong_final_led",   error_led,     0);

    // ---------------- 3,1,8: restart behaviour
    pulse_clear();
    pulse_start();
    feed(4'd3);
    feed(4'd1);
    check("r_progress2", progress, 2);
    feed(4'd8);
    check("r_led",      error_led,     1);
    check("r_progress", progress,      RESTART ? 0 : 2);
    check("r_state",    state_display, 1);
    end_feed();
    check("r_led_off",  error_led,     0);

    // ---------------- three back-to-back mismatches -> FAIL
    pulse_clear();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      feed(4'd0);
      check($sformatf("f_led%0d", i),   error_led,     1);
      check($sformatf("f_err%0d", i),   err_count,     i + 1);
      check($sformatf("f_state%0d", i), state_display, (i == 2) ? 3 : 1);
    end
    feed(4'd3);
    check("f_hold_led",      error_led,     0);
    check("f_hold_err",      err_count,     3);
    check("f_hold_state",    state_display, 3);
    check("f_hold_progress", progress,      0);
    end_feed();

    // ---------------- clear from RUN with progress=3, then replay
    pulse_clear();
    pulse_start();
    for (int i = 0; i < 3; i++) feed(seq[i]);
    number_valid = 1'b0;
    check("c_pre_progress", progress, 3);
    pulse_clear();
    check("c_state",    state_display, 0);
    check("c_progress", progress,      0);
    check("c_loaded",   seq_loaded,    1);
    pulse_start();
    check("c_replay_state", state_display, 1);
    for (int i = 0; i < 3; i++) feed(seq[i]);
    number_valid = 1'b0;
    check("c_replay_progress", progress, 3);

    // ---------------- asynchronous reset from RUN with progress=3
    reset_n = 1'b0;
    #2;
    check("ar_state",    state_display, 0);
    check("ar_progress", progress,      0);
    check("ar_err",      err_count,     0);
    check("ar_led",      error_led,     0);
    check("ar_loaded",   seq_loaded,    0);
    check("ar_ready",    load_ready,    1);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("ar_after_loaded", seq_loaded, 0);

    // ---------------- clear in IDLE flushes the sequence
    for (int i = 0; i < 6; i++) load(seq[i]);
    check("il_loaded", seq_loaded, 1);
    pulse_clear();
    check("il_clr_loaded", seq_loaded, 0);
    check("il_clr_ready",  load_ready, 1);
    pulse_start();
    check("il_start_state", state_display, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
